// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// wb_arbiter_if : register-file writeback arbiter bus bundle
// Rev 1.0
// ============================================================================
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // Pipeline writeback
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  // Long-latency issue / scoreboard
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_waddr;
  logic              issue_busy;
  // Long-latency result handshake
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_waddr;
  logic [DATA_W-1:0] lu_wdata;
  // Decode hazard checks
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              busy1;
  logic              busy2;
  logic              stall_req;
  // Register-file write port
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  issue_valid, issue_waddr,
    output issue_busy,
    input  lu_valid, lu_waddr, lu_wdata,
    output lu_ready,
    input  chk_addr1, chk_addr2,
    output busy1, busy2, stall_req,
    output we, waddr, wdata
  );

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output issue_valid, issue_waddr,
    input  issue_busy,
    output lu_valid, lu_waddr, lu_wdata,
    input  lu_ready,
    output chk_addr1, chk_addr2,
    input  busy1, busy2, stall_req,
    input  we, waddr, wdata
  );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// wb_arbiter : merges pipeline and long-latency writebacks onto one write port
// Rev 1.0
// ============================================================================
module wb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   hold_addr_q;
  logic [DATA_W-1:0]   hold_data_q;
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [REG_NUM-1:0]  busy_q;
  logic [REG_NUM-1:0]  busy_d;

  logic                w_pipe_eff;
  logic                w_lu_take;
  logic                w_lu_nz;
  logic                w_issue_busy;
  logic                w_issue_ok;
  logic                w_clr_en;
  logic [ADDR_W-1:0]   w_clr_addr;

  always_comb begin
    w_pipe_eff   = bus.pipe_we && (bus.pipe_waddr != '0);
    w_lu_take    = bus.lu_valid && (state_q == ST_EMPTY);
    w_lu_nz      = (bus.lu_waddr != '0);
    w_issue_busy = busy_q[bus.issue_waddr];
    w_issue_ok   = bus.issue_valid && (bus.issue_waddr != '0) && !w_issue_busy;

    // The scoreboard entry clears on the edge its result reaches the write port.
    w_clr_en   = 1'b0;
    w_clr_addr = '0;
    if (!w_pipe_eff) begin
      if (state_q == ST_FULL) begin
        w_clr_en   = 1'b1;
        w_clr_addr = hold_addr_q;
      end else if (w_lu_take && w_lu_nz) begin
        w_clr_en   = 1'b1;
        w_clr_addr = bus.lu_waddr;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (w_clr_en) begin
      busy_d[w_clr_addr] = 1'b0;
    end
    if (w_issue_ok) begin
      busy_d[bus.issue_waddr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Priority: pipe > held result > direct long-latency result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      we_q <= 1'b0;
      if (w_pipe_eff) begin
        we_q    <= 1'b1;
        waddr_q <= bus.pipe_waddr;
        wdata_q <= bus.pipe_wdata;
      end else if (state_q == ST_FULL) begin
        we_q    <= 1'b1;
        waddr_q <= hold_addr_q;
        wdata_q <= hold_data_q;
      end else if (w_lu_take && w_lu_nz) begin
        we_q    <= 1'b1;
        waddr_q <= bus.lu_waddr;
        wdata_q <= bus.lu_wdata;
      end

      case (state_q)
        ST_EMPTY: begin
          // A result for r0 is accepted and dropped, so it never occupies the buffer.
          if (w_lu_take && w_lu_nz && w_pipe_eff) begin
            hold_addr_q <= bus.lu_waddr;
            hold_data_q <= bus.lu_wdata;
            state_q     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (!w_pipe_eff) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.lu_ready   = (state_q == ST_EMPTY);
  assign bus.stall_req  = (state_q == ST_FULL);
  assign bus.issue_busy = w_issue_busy;
  assign bus.busy1      = busy_q[bus.chk_addr1];
  assign bus.busy2      = busy_q[bus.chk_addr2];

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wb_arbiter : directed vector bench for wb_arbiter
// Rev 1.0
// ============================================================================
module tb_wb_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_arbiter #(.DATA_W(32), .ADDR_W(5), .REG_NUM(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pwe;  logic [4:0] pa; logic [31:0] pd;
    logic        iv;   logic [4:0] ia;
    logic        lv;   logic [4:0] la; logic [31:0] ld;
    logic [4:0]  c1;   logic [4:0] c2;
    logic        we;   logic [4:0] wa; logic [31:0] wd;
    logic        rdy;  logic stl; logic b1; logic b2; logic ib;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(
    input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
    input logic iv, input logic [4:0] ia,
    input logic lv, input logic [4:0] la, input logic [31:0] ld,
    input logic [4:0] c1, input logic [4:0] c2,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic rdy, input logic stl, input logic b1, input logic b2, input logic ib);
    vec_t v;
    v.pwe = pwe; v.pa = pa; v.pd = pd; v.iv = iv; v.ia = ia;
    v.lv = lv; v.la = la; v.ld = ld; v.c1 = c1; v.c2 = c2;
    v.we = we; v.wa = wa; v.wd = wd; v.rdy = rdy; v.stl = stl;
    v.b1 = b1; v.b2 = b2; v.ib = ib;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.pipe_we     = v.pwe; bus.pipe_waddr = v.pa; bus.pipe_wdata = v.pd;
    bus.issue_valid = v.iv;  bus.issue_waddr = v.ia;
    bus.lu_valid    = v.lv;  bus.lu_waddr   = v.la; bus.lu_wdata   = v.ld;
    bus.chk_addr1   = v.c1;  bus.chk_addr2  = v.c2;
  endtask

  task automatic idle();
    vec_t v;
    v = mk(0,0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0);
    drive(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();

    // pwe pa pd | iv ia | lv la ld | c1 c2 | we wa wd | rdy stl b1 b2 ib
    vt[0]  = mk(1, 5, 32'h1234, 0,0, 0,0,0,            5,9, 1, 5,32'h1234, 1,0, 0,0,0);
    vt[1]  = mk(1, 0, 32'h5555, 0,0, 0,0,0,            5,9, 0, 5,32'h1234, 1,0, 0,0,0);
    vt[2]  = mk(0, 0, 0,        1,9, 0,0,0,            9,0, 0, 5,32'h1234, 1,0, 1,0,1);
    vt[3]  = mk(0, 0, 0,        1,9, 1,9,32'hDEAD,     9,0, 1, 9,32'hDEAD, 1,0, 0,0,0);
    vt[4]  = mk(0, 0, 0,        1,3, 0,0,0,            3,4, 0, 9,32'hDEAD, 1,0, 1,0,1);
    vt[5]  = mk(1, 4, 32'hB0,   0,0, 1,3,32'hA0,       3,4, 1, 4,32'hB0,   0,1, 1,0,0);
    vt[6]  = mk(0, 0, 0,        0,0, 0,0,0,            3,4, 1, 3,32'hA0,   1,0, 0,0,0);
    vt[7]  = mk(0, 0, 0,        0,0, 0,0,0,            3,4, 0, 3,32'hA0,   1,0, 0,0,0);
    vt[8]  = mk(0, 0, 0,        1,6, 0,0,0,            6,0, 0, 3,32'hA0,   1,0, 1,0,1);
    vt[9]  = mk(1, 1, 32'h11,   0,0, 1,6,32'h66,       6,0, 1, 1,32'h11,   0,1, 1,0,0);
    vt[10] = mk(1, 2, 32'h22,   0,0, 0,0,0,            6,0, 1, 2,32'h22,   0,1, 1,0,0);
    vt[11] = mk(1,12, 32'h1212, 0,0, 0,0,0,            6,0, 1,12,32'h1212, 0,1, 1,0,0);
    vt[12] = mk(1, 0, 32'hFFFF, 0,0, 0,0,0,            6,0, 1, 6,32'h66,   1,0, 0,0,0);
    vt[13] = mk(0, 0, 0,        0,0, 1,0,32'h777,      6,0, 0, 6,32'h66,   1,0, 0,0,0);
    vt[14] = mk(0, 0, 0,        1,8, 1,8,32'h88,       8,0, 1, 8,32'h88,   1,0, 1,0,1);
    vt[15] = mk(1, 8, 32'h99,   0,8, 0,0,0,            8,6, 1, 8,32'h99,   1,0, 1,0,1);

    // Reset held two cycles, released away from the edge
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.we",        32'(bus.we),        32'd0);
    chk("rst.waddr",     32'(bus.waddr),     32'd0);
    chk("rst.wdata",     bus.wdata,          32'd0);
    chk("rst.lu_ready",  32'(bus.lu_ready),  32'd1);
    chk("rst.stall_req", 32'(bus.stall_req), 32'd0);
    for (int a = 0; a < 32; a += 4) begin
      bus.chk_addr1 = 5'(a);
      bus.chk_addr2 = 5'(31 - a);
      #1;
      chk($sformatf("rst.busy1[%0d]", a),      32'(bus.busy1), 32'd0);
      chk($sformatf("rst.busy2[%0d]", 31 - a), 32'(bus.busy2), 32'd0);
    end

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vt[i]);
      step();
      chk($sformatf("v%0d.we", i),         32'(bus.we),         32'(vt[i].we));
      chk($sformatf("v%0d.waddr", i),      32'(bus.waddr),      32'(vt[i].wa));
      chk($sformatf("v%0d.wdata", i),      bus.wdata,           vt[i].wd);
      chk($sformatf("v%0d.lu_ready", i),   32'(bus.lu_ready),   32'(vt[i].rdy));
      chk($sformatf("v%0d.stall_req", i),  32'(bus.stall_req),  32'(vt[i].stl));
      chk($sformatf("v%0d.busy1", i),      32'(bus.busy1),      32'(vt[i].b1));
      chk($sformatf("v%0d.busy2", i),      32'(bus.busy2),      32'(vt[i].b2));
      chk($sformatf("v%0d.issue_busy", i), 32'(bus.issue_busy), 32'(vt[i].ib));
    end

    // Reset while a held result is pending and r7 is busy
    @(negedge clk);
    idle();
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd7;
    bus.chk_addr1   = 5'd7;
    step();
    chk("r6.busy7_set", 32'(bus.busy1), 32'd1);
    @(negedge clk);
    bus.issue_valid = 1'b0; bus.issue_waddr = 5'd0;
    bus.lu_valid = 1'b1; bus.lu_waddr = 5'd7; bus.lu_wdata = 32'h7777;
    bus.pipe_we  = 1'b1; bus.pipe_waddr = 5'd5; bus.pipe_wdata = 32'h5555;
    step();
    chk("r6.full_waddr", 32'(bus.waddr),     32'd5);
    chk("r6.full_stall", 32'(bus.stall_req), 32'd1);
    @(negedge clk);
    idle();
    bus.chk_addr1 = 5'd7;
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("r6.we",        32'(bus.we),        32'd0);
    chk("r6.waddr",     32'(bus.waddr),     32'd0);
    chk("r6.wdata",     bus.wdata,          32'd0);
    chk("r6.lu_ready",  32'(bus.lu_ready),  32'd1);
    chk("r6.stall_req", 32'(bus.stall_req), 32'd0);
    chk("r6.busy7",     32'(bus.busy1),     32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("r6.no_drain%0d.we", k),    32'(bus.we),    32'd0);
      chk($sformatf("r6.no_drain%0d.wdata", k), bus.wdata,      32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
